output_port_alloc: RTL and testbench
====================================

# output_port_alloc

Wormhole output-port allocator for one router output port. Arbitrates up to NUM_REQ input ports with a round-robin policy and holds the port for the winner from head flit to tail flit. Tracks credits for the downstream input buffer so that no flit is granted without a free slot. The router controller instantiates one per output direction, alongside the per-input route-computation logic.

## Interface

Parameters:
- NUM_REQ, 4: number of requesting input ports; power of two, ≥2.
- CREDITS, 4: downstream buffer depth; initial and maximum credit count.
- STALL_LIMIT, 15: watchdog threshold in cycles; used only with the watchdog macro.

Ports (clock and reset are one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_i  in  NUM_REQ  per-input request; a flit destined for this port is at that input's head.
- tail_i  in  NUM_REQ  tail flag of the flit at each input head; valid only with req_i.
- credit_return_i  in  1  downstream freed one slot this cycle.
- grant_o  out  NUM_REQ  one-hot grant; all zero when no grant.
- grant_v_o  out  1  a flit transfers this cycle; equals OR of grant_o.
- locked_o  out  1  port is held by a packet (LOCKED state).
- owner_o  out  $clog2(NUM_REQ)  current or last lock owner.
- credits_o  out  $clog2(CREDITS+1)  registered credit count.
- overflow_o  out  1  sticky; credit return received while count = CREDITS.
- stall_o  out  1  one-cycle watchdog-release pulse.

## Operation

- Registered state: fsm (IDLE/LOCKED), rr_ptr, owner, credits, overflow, stall counter.
- Grants are combinational from the registered state plus req_i/tail_i. There is no grant whenever credits = 0.
- IDLE:
  - Winner is the first asserted req_i scanning from rr_ptr upward, wrapping mod NUM_REQ.
  - Winner with tail_i (single-flit packet): stay IDLE; rr_ptr ← winner+1.
  - Winner without tail_i: go to LOCKED; owner ← winner.
- LOCKED:
  - Only req_i[owner] is considered; all other requests are ignored.
  - Grant with tail_i[owner]: go to IDLE; rr_ptr ← owner+1 mod NUM_REQ.
  - No grant: hold the state.
- Credits:
  - Grant only: credits − 1.
  - credit_return_i only: credits + 1, saturating at CREDITS; a return at CREDITS sets overflow_o.
  - Grant and return together: unchanged.
  - A return at credits = 0 does not enable a grant in the same cycle.
- Reset values, effective mid-packet too: fsm=IDLE, rr_ptr=0, owner=0, credits=CREDITS, overflow_o=0, stall counter=0, stall_o=0.
  - Combinational outputs in the reset cycle follow the reset state: grants are computed from the state before the edge. After the edge, grant_o=0 until a new request arrives.

## Timing

- Request to grant: 0 cycles (same cycle).
- State and credit effects are visible the cycle after the grant.
- Back-to-back flits of a locked packet can be granted every cycle while credits > 0.
- Unlock to new winner: 0 idle cycles. The cycle after a tail grant is IDLE arbitration with the advanced rr_ptr.
- credits_o lags a grant by 1 cycle.
- With CREDITS flits outstanding and no returns, grant_v_o stays low until 1 cycle after the first return.

## Configuration

- ALLOC_WATCHDOG_EN defined:
  - In LOCKED, a counter increments each cycle req_i[owner]=0. Credit-starved cycles with the request high do not count; they clear the counter.
  - When the count reaches STALL_LIMIT: stall_o pulses for one cycle, fsm ← IDLE, rr_ptr ← owner+1, counter ← 0.
  - The counter clears on any grant and on leaving LOCKED.
- Not defined: stall_o is tied to 0, no counter is built, and a lock is held indefinitely until its tail flit.

## Test plan

- Reset, then req_i=4'b1111 with all tail_i=1 and credit_return_i pulsed every cycle -> grants rotate 0,1,2,3,0; credits_o stays at 4.
- req_i=4'b0110 with tail_i[1]=0 for 3 flits then tail -> grant_o=4'b0010 for 4 consecutive cycles and locked_o=1 during the packet. Input 2 is then granted on the next cycle; input 2 is never granted mid-packet.
- CREDITS=4, continuous single-flit requests from input 0, no returns -> 4 grants, then grant_v_o=0. A return in cycle N gives a grant in N+1.
- Return and grant in the same cycle at credits=2 -> credits_o remains 2. A return at credits=4 -> credits_o=4 and overflow_o=1, sticky until rst.
- rst asserted mid-packet (locked_o=1, credits=1) -> next cycle locked_o=0, credits_o=4, rr_ptr=0, so req_i=4'b1010 grants input 1.
- ALLOC_WATCHDOG_EN, STALL_LIMIT=15: lock input 2, then drop req_i[2] -> stall_o pulses on the 15th idle cycle and locked_o=0. Waiting input 3 is granted next.

Source files
------------

// File: rtl/output_port_alloc.sv
// Wormhole output-port allocator: round-robin arbitration, packet locking,
// downstream credit tracking. Optional watchdog: ALLOC_WATCHDOG_EN.
module output_port_alloc #(
  parameter int NUM_REQ     = 4,
  parameter int CREDITS     = 4,
  parameter int STALL_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0]           tail_i,
  input  logic                         credit_return_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         grant_v_o,
  output logic                         locked_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic [$clog2(CREDITS+1)-1:0] credits_o,
  output logic                         overflow_o,
  output logic                         stall_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        fsm;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] credits;
  logic          overflow;

  logic [IW-1:0]      win;
  logic [IW-1:0]      idx;
  logic               win_v;
  logic               win_tail;
  logic [NUM_REQ-1:0] grant;

`ifdef ALLOC_WATCHDOG_EN
  localparam int SW = $clog2(STALL_LIMIT+1);
  localparam logic [SW-1:0] SLAST = SW'(STALL_LIMIT-1);
  logic [SW-1:0] stall_cnt;
  logic          stall_q;
  logic          release_w;

  // Watchdog fires when the owner has been absent for STALL_LIMIT cycles
  always_comb begin
    release_w = (fsm == LOCKED) && !req_i[owner] && (stall_cnt == SLAST);
  end
`endif

  // Pick the winner: owner while locked, else round-robin from rr_ptr
  always_comb begin
    win   = owner;
    win_v = 1'b0;
    idx   = '0;
    grant = '0;
    if (credits != '0) begin
      if (fsm == LOCKED) begin
        win   = owner;
        win_v = req_i[owner];
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = rr_ptr + IW'(i);
          if (!win_v && req_i[idx]) begin
            win   = idx;
            win_v = 1'b1;
          end
        end
      end
    end
    if (win_v) grant[win] = 1'b1;
    win_tail = win_v & tail_i[win];
  end

  // Lock state, round-robin pointer and owner
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (win_v) begin
            if (win_tail) begin
              rr_ptr <= win + 1'b1;
            end else begin
              fsm   <= LOCKED;
              owner <= win;
            end
          end
        end
        LOCKED: begin
          if (win_tail) begin
            fsm    <= IDLE;
            rr_ptr <= owner + 1'b1;
          end
`ifdef ALLOC_WATCHDOG_EN
          else if (release_w) begin
            fsm    <= IDLE;
            rr_ptr <= owner + 1'b1;
          end
`endif
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Credit counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      credits  <= CMAX;
      overflow <= 1'b0;
    end else begin
      if (win_v && !credit_return_i) begin
        credits <= credits - 1'b1;
      end else if (!win_v && credit_return_i) begin
        if (credits == CMAX) overflow <= 1'b1;
        else                 credits  <= credits + 1'b1;
      end
    end
  end

`ifdef ALLOC_WATCHDOG_EN
  // Count owner-absent cycles while locked; pulse stall on release
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_q <= release_w;
      if (fsm != LOCKED || req_i[owner] || release_w) stall_cnt <= '0;
      else                                              stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

  assign grant_o    = grant;
  assign grant_v_o  = win_v;
  assign locked_o   = (fsm == LOCKED);
  assign owner_o    = owner;
  assign credits_o  = credits;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_output_port_alloc.sv
// Directed bench for output_port_alloc with a grant scoreboard.
// Checks arbitration, locking, credits, reset and the watchdog build.
module tb_output_port_alloc;

`ifdef ALLOC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] tail = '0;
  logic       ret = 1'b0;
  logic [3:0] grant_o;
  logic       grant_v_o;
  logic       locked_o;
  logic [1:0] owner_o;
  logic [2:0] credits_o;
  logic       overflow_o;
  logic       stall_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  output_port_alloc #(
    .NUM_REQ(4), .CREDITS(4), .STALL_LIMIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .tail_i(tail),
    .credit_return_i(ret),
    .grant_o(grant_o), .grant_v_o(grant_v_o),
    .locked_o(locked_o), .owner_o(owner_o),
    .credits_o(credits_o), .overflow_o(overflow_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check combinational grant, then step past the edge
  task automatic cyc(input logic [3:0] r, input logic [3:0] t,
                     input logic rt, input logic [3:0] eg,
                     input string tag);
    logic [3:0] e;
    @(negedge clk);
    req = r; tail = t; ret = rt;
    exp_q.push_back(eg);
    #1;
    e = exp_q.pop_front();
    chk(tag, 32'(grant_o), 32'(e));
    chk({tag, "_v"}, 32'(grant_v_o), 32'(|e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, "rst0");
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, "rst1");
    rst = 1'b0;
    chk("rst_credits", 32'(credits_o), 32'd4);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);

    // Round-robin rotation with single-flit packets
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, "rr0");
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0010, "rr1");
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0100, "rr2");
    cyc(4'b1111, 4'b1111, 1'b1, 4'b1000, "rr3");
    cyc(4'b1111, 4'b1111, 1'b1, 4'b0001, "rr4");
    chk("rr_credits", 32'(credits_o), 32'd4);

    // 4-flit packet on input 1; input 2 waits
    cyc(4'b0110, 4'b0000, 1'b1, 4'b0010, "pk0");
    chk("pk0_locked", 32'(locked_o), 32'd1);
    chk("pk0_owner", 32'(owner_o), 32'd1);
    cyc(4'b0110, 4'b0000, 1'b1, 4'b0010, "pk1");
    chk("pk1_locked", 32'(locked_o), 32'd1);
    cyc(4'b0110, 4'b0000, 1'b1, 4'b0010, "pk2");
    chk("pk2_locked", 32'(locked_o), 32'd1);
    cyc(4'b0110, 4'b0010, 1'b1, 4'b0010, "pk3");
    chk("pk3_locked", 32'(locked_o), 32'd0);
    cyc(4'b0110, 4'b0110, 1'b1, 4'b0100, "pk4");

    // Credit exhaustion from input 0
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0001, "cr0");
    chk("cr0_credits", 32'(credits_o), 32'd3);
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0001, "cr1");
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0001, "cr2");
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0001, "cr3");
    chk("cr3_credits", 32'(credits_o), 32'd0);
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0000, "cr4");
    cyc(4'b0001, 4'b0001, 1'b1, 4'b0000, "cr_ret");
    chk("cr_ret_credits", 32'(credits_o), 32'd1);
    cyc(4'b0001, 4'b0001, 1'b0, 4'b0001, "cr_after");
    chk("cr_after_credits", 32'(credits_o), 32'd0);

    // Simultaneous grant and return, then overflow
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "rt0");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "rt1");
    chk("rt1_credits", 32'(credits_o), 32'd2);
    cyc(4'b0001, 4'b0001, 1'b1, 4'b0001, "both");
    chk("both_credits", 32'(credits_o), 32'd2);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "rt2");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "rt3");
    chk("full_credits", 32'(credits_o), 32'd4);
    chk("full_ovf", 32'(overflow_o), 32'd0);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, "ovf");
    chk("ovf_credits", 32'(credits_o), 32'd4);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, "ovf_hold");
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Lock input 2 with input 3 also requesting, then reset mid-packet
    cyc(4'b1100, 4'b0000, 1'b0, 4'b0100, "ml0");
    cyc(4'b1100, 4'b0000, 1'b0, 4'b0100, "ml1");
    cyc(4'b1100, 4'b0000, 1'b0, 4'b0100, "ml2");
    chk("ml_locked", 32'(locked_o), 32'd1);
    chk("ml_owner", 32'(owner_o), 32'd2);
    chk("ml_credits", 32'(credits_o), 32'd1);
    rst = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, "mrst");
    rst = 1'b0;
    chk("mrst_locked", 32'(locked_o), 32'd0);
    chk("mrst_credits", 32'(credits_o), 32'd4);
    chk("mrst_ovf", 32'(overflow_o), 32'd0);
    chk("mrst_owner", 32'(owner_o), 32'd0);
    cyc(4'b1010, 4'b1010, 1'b0, 4'b0010, "mrst_rr");

    // Lock input 2, drop its request while input 3 waits
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100, "wd_lock");
    chk("wd_locked", 32'(locked_o), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      cyc(4'b1000, 4'b1000, 1'b0, 4'b0000, $sformatf("wd_idle%0d", i));
      chk($sformatf("wd_stall%0d", i), 32'(stall_o),
          32'(WD && i == 15));
      chk($sformatf("wd_locked%0d", i), 32'(locked_o),
          32'(!(WD && i == 15)));
    end
    cyc(4'b1000, 4'b1000, 1'b0, WD ? 4'b1000 : 4'b0000, "wd_next");
    chk("wd_stall_end", 32'(stall_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
